// File: rtl/m_pile_tracker.sv
// Column-height tracker for the drop-piece board: per-column pile counts,
// move-history stack for undo, move counter and full flags, serviced over
// a valid/ready request port with a registered one-cycle response pulse.
module m_pile_tracker #(
    parameter int COLS   = 7,
    parameter int ROWS   = 6,
    parameter int CNT_W  = $clog2(ROWS + 1),
    parameter int COL_W  = $clog2(COLS),
    parameter int MOVE_W = $clog2(COLS * ROWS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    input  logic [1:0]            i_op,
    input  logic [COL_W-1:0]      i_col,
    output logic                  o_ready,
    output logic                  o_resp_valid,
    output logic                  o_resp_ok,
    output logic [COL_W-1:0]      o_resp_col,
    output logic [CNT_W-1:0]      o_resp_row,
    output logic [COLS*CNT_W-1:0] o_pile_count_array,
    output logic [COLS-1:0]       o_col_full,
    output logic                  o_board_full,
    output logic [MOVE_W-1:0]     o_move_count
);

    localparam int DEPTH = COLS * ROWS;
    localparam int SW_W  = $clog2(COLS + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_UNDO_RD = 2'd1;
    localparam logic [1:0] S_UNDO_WR = 2'd2;
    localparam logic [1:0] S_CLEAR   = 2'd3;

    localparam logic [1:0] OP_DROP  = 2'b00;
    localparam logic [1:0] OP_UNDO  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    localparam logic [CNT_W-1:0]  ROWS_C   = CNT_W'(ROWS);
    localparam logic [COL_W:0]    COLS_C   = (COL_W + 1)'(COLS);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [SW_W-1:0]   SW_LAST  = SW_W'(COLS - 1);
    localparam logic [SW_W-1:0]   SW_END   = SW_W'(COLS);
    localparam logic [MOVE_W-1:0] MOVE_MAX = MOVE_W'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  counts_q [COLS];
    logic [CNT_W-1:0]  counts_d [COLS];
    logic [MOVE_W-1:0] mc_q, mc_d;
    logic [SW_W-1:0]   sweep_q, sweep_d;
    logic [COL_W-1:0]  pop_col_q, pop_col_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_ok_q, resp_ok_d;
    logic [COL_W-1:0]  resp_col_q, resp_col_d;
    logic [CNT_W-1:0]  resp_row_q, resp_row_d;

    logic [COL_W-1:0]  hist_q [DEPTH];
    logic              hist_we;
    logic [MOVE_W-1:0] hist_waddr;
    logic [COL_W-1:0]  hist_wdata;

    logic              col_ok;
    logic [CNT_W-1:0]  cur_cnt;
    logic              sw_en;
    logic [SW_W-1:0]   sw_idx;

    // Next-state, counter, history-write and response computation
    always_comb begin
        state_d      = state_q;
        counts_d     = counts_q;
        mc_d         = mc_q;
        sweep_d      = sweep_q;
        pop_col_d    = pop_col_q;
        resp_valid_d = 1'b0;
        resp_ok_d    = resp_ok_q;
        resp_col_d   = resp_col_q;
        resp_row_d   = resp_row_q;
        hist_we      = 1'b0;
        hist_waddr   = mc_q;
        hist_wdata   = i_col;
        sw_en        = 1'b0;
        sw_idx       = '0;
        col_ok       = ({1'b0, i_col} < COLS_C);
        cur_cnt      = col_ok ? counts_q[i_col] : '0;

        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    case (i_op)
                        OP_DROP: begin
                            resp_valid_d = 1'b1;
                            resp_col_d   = i_col;
                            resp_row_d   = cur_cnt;
                            if (col_ok && (cur_cnt < ROWS_C)) begin
                                resp_ok_d        = 1'b1;
                                counts_d[i_col]  = cur_cnt + CNT_W'(1);
                                hist_we          = 1'b1;
                                mc_d             = mc_q + MOVE_W'(1);
                            end else begin
                                resp_ok_d = 1'b0;
                            end
                        end
                        OP_UNDO: begin
                            if (mc_q == '0) begin
                                resp_valid_d = 1'b1;
                                resp_ok_d    = 1'b0;
                                resp_col_d   = '0;
                                resp_row_d   = '0;
                            end else begin
                                pop_col_d = hist_q[mc_q - MOVE_W'(1)];
                                state_d   = S_UNDO_RD;
                            end
                        end
                        OP_CLEAR: begin
                            // Column 0 is swept on the accept edge so the
                            // response lands in the last of COLS busy cycles.
                            sw_en   = 1'b1;
                            sw_idx  = '0;
                            sweep_d = SW_W'(1);
                            state_d = S_CLEAR;
                        end
                        default: begin
                            resp_valid_d = 1'b1;
                            resp_ok_d    = 1'b0;
                            resp_col_d   = '0;
                            resp_row_d   = '0;
                        end
                    endcase
                end
            end
            S_UNDO_RD: begin
                counts_d[pop_col_q] = counts_q[pop_col_q] - CNT_W'(1);
                mc_d         = mc_q - MOVE_W'(1);
                resp_valid_d = 1'b1;
                resp_ok_d    = 1'b1;
                resp_col_d   = pop_col_q;
                resp_row_d   = counts_q[pop_col_q] - CNT_W'(1);
                state_d      = S_UNDO_WR;
            end
            S_UNDO_WR: begin
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                if (sweep_q == SW_END) begin
                    state_d = S_IDLE;
                end else begin
                    sw_en   = 1'b1;
                    sw_idx  = sweep_q;
                    sweep_d = sweep_q + SW_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (sw_en) begin
            counts_d[sw_idx[COL_W-1:0]] = '0;
            if (sw_idx == SW_LAST) begin
                mc_d         = '0;
                resp_valid_d = 1'b1;
                resp_ok_d    = 1'b1;
                resp_col_d   = COL_LAST;
                resp_row_d   = '0;
            end
        end
    end

    // Control, count and response registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            for (int unsigned i = 0; i < COLS; i++) begin
                counts_q[i] <= '0;
            end
            mc_q         <= '0;
            sweep_q      <= '0;
            pop_col_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_col_q   <= '0;
            resp_row_q   <= '0;
        end else begin
            state_q      <= state_d;
            counts_q     <= counts_d;
            mc_q         <= mc_d;
            sweep_q      <= sweep_d;
            pop_col_q    <= pop_col_d;
            resp_valid_q <= resp_valid_d;
            resp_ok_q    <= resp_ok_d;
            resp_col_q   <= resp_col_d;
            resp_row_q   <= resp_row_d;
        end
    end

    // Move-history stack: one entry written per successful drop
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else if (hist_we) begin
            hist_q[hist_waddr] <= hist_wdata;
        end
    end

    // Outputs derived from registered state only
    always_comb begin
        o_ready      = (state_q == S_IDLE);
        o_resp_valid = resp_valid_q;
        o_resp_ok    = resp_ok_q;
        o_resp_col   = resp_col_q;
        o_resp_row   = resp_row_q;
        o_move_count = mc_q;
        o_board_full = (mc_q == MOVE_MAX);
        o_pile_count_array = '0;
        o_col_full         = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            o_pile_count_array[c*CNT_W +: CNT_W] = counts_q[c];
            o_col_full[c] = (counts_q[c] == ROWS_C);
        end
    end

endmodule
